// File: rtl/key_conditioner.sv
// Front-panel input conditioner for the alarm-clock Timer: 2-flop sync and debounce on all four
// inputs, plus single-cycle step pulses with auto-repeat for the hours/mins keys.
//   state  | meaning
//   IDLE   | key released, waiting for a debounced press
//   DELAY  | first pulse sent, counting to the first auto-repeat
//   REPEAT | auto-repeating, one pulse every REPEAT_RATE cycles
module key_conditioner #(
  parameter int DEBOUNCE_CNT = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic hours_key_raw,
  input  logic mins_key_raw,
  input  logic set_time_raw,
  input  logic alarm_raw,
  output logic hours_set,
  output logic mins_set,
  output logic set_time,
  output logic alarm
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_t;

  logic [3:0] w_raw;
  logic [3:0] w_st;
  logic [1:0] w_pulse_q;

  assign w_raw = {alarm_raw, set_time_raw, mins_key_raw, hours_key_raw};

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic             r_s1;
    logic             r_s2;
    logic             r_st;
    logic [CNT_W-1:0] r_dc;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
        r_st <= 1'b0;
        r_dc <= '0;
      end else begin
        r_s1 <= w_raw[i];
        r_s2 <= r_s1;
        if (r_s2 == r_st) begin
          r_dc <= '0;
        end else if (r_dc == DB_LAST) begin
          r_st <= r_s2;
          r_dc <= '0;
        end else begin
          r_dc <= r_dc + CNT_W'(1);
        end
      end
    end

    assign w_st[i] = r_st;
  end

  // Keys 0 (hours) and 1 (mins) run identical, fully independent FSMs.
  for (genvar k = 0; k < 2; k++) begin : g_key
    key_state_t       r_state;
    key_state_t       w_next;
    logic [CNT_W-1:0] r_rc;
    logic [CNT_W-1:0] w_rc_next;
    logic             r_pulse;
    logic             w_pulse;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_rc    <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_next;
        r_rc    <= w_rc_next;
        r_pulse <= w_pulse;
      end
    end

    always_comb begin
      w_next    = r_state;
      w_rc_next = r_rc;
      w_pulse   = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_st[k]) begin
            w_pulse   = 1'b1;
            w_rc_next = '0;
            w_next    = DELAY;
          end
        end
        DELAY: begin
          if (!w_st[k]) begin
            w_rc_next = '0;
            w_next    = IDLE;
          end else if (r_rc == RD_LAST) begin
            w_pulse   = 1'b1;
            w_rc_next = '0;
            w_next    = REPEAT;
          end else begin
            w_rc_next = r_rc + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!w_st[k]) begin
            w_rc_next = '0;
            w_next    = IDLE;
          end else if (r_rc == RR_LAST) begin
            w_pulse   = 1'b1;
            w_rc_next = '0;
          end else begin
            w_rc_next = r_rc + CNT_W'(1);
          end
        end
        default: begin
          w_rc_next = '0;
          w_next    = IDLE;
        end
      endcase
    end

    assign w_pulse_q[k] = r_pulse;
  end

  assign hours_set = w_pulse_q[0];
  assign mins_set  = w_pulse_q[1];
  assign set_time  = w_st[2];
  assign alarm     = w_st[3];

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: per-cycle comparison of all four outputs against the expected
// pulse schedule and debounced levels, via an expectation queue.
module tb_key_conditioner;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hours_key_raw = 1'b0;
  logic mins_key_raw = 1'b0;
  logic set_time_raw = 1'b0;
  logic alarm_raw = 1'b0;
  logic hours_set, mins_set, set_time, alarm;

  key_conditioner #(
    .DEBOUNCE_CNT(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hours_key_raw(hours_key_raw),
    .mins_key_raw (mins_key_raw),
    .set_time_raw (set_time_raw),
    .alarm_raw    (alarm_raw),
    .hours_set    (hours_set),
    .mins_set     (mins_set),
    .set_time     (set_time),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    string      name;
    int         k;
  } exp_t;

  typedef struct {
    int   h_len;
    int   m_len;
    logic set_lvl;
    logic alarm_lvl;
    int   cycles;
    string name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_set_prev = 1'b0;
  logic exp_alarm_prev = 1'b0;

  // Key raised from E0 and held len cycles: first pulse at E(DB+2), first repeat RD later,
  // then every RR; the last possible pulse is the edge where the release debounces.
  function automatic logic key_exp(input int k, input int len);
    if (len < DB) return 1'b0;
    if (k < DB + 2 || k > len + DB + 1) return 1'b0;
    if (k == DB + 2) return 1'b1;
    if (k >= DB + 2 + RD && ((k - (DB + 2 + RD)) % RR) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_pop();
    exp_t e;
    logic [3:0] got;
    got = {hours_set, mins_set, set_time, alarm};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got h/m/s/a=%b", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s k=%0d got h/m/s/a=%b expected %b", e.name, e.k, got, e.v);
      end
    end
  endtask

  task automatic tick(input logic h, input logic m, input logic s, input logic a,
                      input logic [3:0] ev, input string nm, input int k);
    hours_key_raw = h;
    mins_key_raw  = m;
    set_time_raw  = s;
    alarm_raw     = a;
    exp_q.push_back('{ev, nm, k});
    @(posedge clk);
    @(negedge clk);
    compare_pop();
  endtask

  initial begin
    logic s_lvl;
    logic [3:0] ev;

    vecs[0] = '{3,  0,  1'b0, 1'b0, 30, "glitch3"};
    vecs[1] = '{10, 0,  1'b1, 1'b0, 40, "single_press"};
    vecs[2] = '{0,  60, 1'b1, 1'b1, 80, "mins_repeat"};
    vecs[3] = '{10, 10, 1'b0, 1'b1, 40, "both_keys"};
    vecs[4] = '{30, 45, 1'b0, 1'b0, 60, "indep_lens"};

    @(negedge clk);
    // Reset held with raw inputs toggling
    for (int k = 0; k < 8; k++)
      tick(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 4'b0000, "in_reset", k);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "in_reset", 8);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "in_reset", 9);
    reset = 1'b0;
    for (int k = 0; k < 10; k++)
      tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "after_reset", k);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < vecs[r].cycles; k++) begin
        ev = {key_exp(k, vecs[r].h_len), key_exp(k, vecs[r].m_len),
              (k >= DB + 1) ? vecs[r].set_lvl : exp_set_prev,
              (k >= DB + 1) ? vecs[r].alarm_lvl : exp_alarm_prev};
        tick(k < vecs[r].h_len, k < vecs[r].m_len, vecs[r].set_lvl, vecs[r].alarm_lvl,
             ev, vecs[r].name, k);
      end
      exp_set_prev   = vecs[r].set_lvl;
      exp_alarm_prev = vecs[r].alarm_lvl;
    end

    // Bouncing set_time switch while hours key is held into REPEAT
    for (int k = 0; k < 38; k++) begin
      s_lvl = (k < 12) ? (((k / 2) % 2) == 0) : 1'b1;
      ev = {key_exp(k, 1000), 1'b0, (k >= 12 + DB + 1), 1'b0};
      tick(1'b1, 1'b0, s_lvl, 1'b0, ev, "bounce_repeat", k);
    end

    // Reset in the middle of REPEAT
    reset = 1'b1;
    #1;
    exp_q.push_back('{4'b0000, "reset_async", 0});
    compare_pop();
    for (int k = 0; k < 10; k++)
      tick(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "reset_held", k);

    // Release reset with key and switch still high: both re-qualify as fresh
    reset = 1'b0;
    for (int k = 0; k < 46; k++) begin
      ev = {key_exp(k, 16), 1'b0, (k >= DB + 1), 1'b0};
      tick(k < 16, 1'b0, 1'b1, 1'b0, ev, "fresh_after_reset", k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
